// File: rtl/encrypt_arbiter.sv
// encrypt_arbiter: shares one 4-phase encrypt core between two 4-phase requesters.
// A requester is granted and its key/plaintext latched. One full core transaction
// runs, the ciphertext is captured into that requester's holding register, and
// the requester's handshake is then completed.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   req0/ack0/k0/m0/c0     requester 0 (4-phase; c0 valid while ack0=1)
//   req1/ack1/k1/m1/c1     requester 1 (same as requester 0)
//   core_req/core_ack      4-phase handshake to the encrypt core
//   core_k/core_m/core_c   core key, plaintext and ciphertext
//
// Configuration macro: ENCRYPT_ARB_FIXED_PRIO_EN
//   defined   -> requester 0 always wins a tie (requester 1 may starve)
//   undefined -> round-robin tie break using the last-served pointer

`ifndef N_K
`define N_K 128
`endif
`ifndef N_B
`define N_B 128
`endif

module encrypt_arbiter #(
   parameter int unsigned N_K = `N_K,
   parameter int unsigned N_B = `N_B
) (
   input  logic           clk,
   input  logic           rst_n,
   // requester 0
   input  logic           req0,
   output logic           ack0,
   input  logic [N_K-1:0] k0,
   input  logic [N_B-1:0] m0,
   output logic [N_B-1:0] c0,
   // requester 1
   input  logic           req1,
   output logic           ack1,
   input  logic [N_K-1:0] k1,
   input  logic [N_B-1:0] m1,
   output logic [N_B-1:0] c1,
   // encrypt core
   output logic           core_req,
   input  logic           core_ack,
   output logic [N_K-1:0] core_k,
   output logic [N_B-1:0] core_m,
   input  logic [N_B-1:0] core_c
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      RELEASE = 2'd2,
      RESPOND = 2'd3
   } state_t;

   state_t         state_q, state_d;
   logic           g_q, g_d;
   logic           last_q, last_d;
   logic           ack0_q, ack0_d;
   logic           ack1_q, ack1_d;
   logic           core_req_q, core_req_d;
   logic [N_K-1:0] core_k_q, core_k_d;
   logic [N_B-1:0] core_m_q, core_m_d;
   logic [N_B-1:0] c0_q, c0_d;
   logic [N_B-1:0] c1_q, c1_d;

   logic elig0, elig1, pick1, req_g;

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         g_q        <= 1'b0;
         last_q     <= 1'b1;
         ack0_q     <= 1'b0;
         ack1_q     <= 1'b0;
         core_req_q <= 1'b0;
         core_k_q   <= '0;
         core_m_q   <= '0;
         c0_q       <= '0;
         c1_q       <= '0;
      end else begin
         state_q    <= state_d;
         g_q        <= g_d;
         last_q     <= last_d;
         ack0_q     <= ack0_d;
         ack1_q     <= ack1_d;
         core_req_q <= core_req_d;
         core_k_q   <= core_k_d;
         core_m_q   <= core_m_d;
         c0_q       <= c0_d;
         c1_q       <= c1_d;
      end
   end

   // Next-state and output logic
   always_comb begin
      state_d    = state_q;
      g_d        = g_q;
      last_d     = last_q;
      ack0_d     = ack0_q;
      ack1_d     = ack1_q;
      core_req_d = core_req_q;
      core_k_d   = core_k_q;
      core_m_d   = core_m_q;
      c0_d       = c0_q;
      c1_d       = c1_q;

      // A requester already holding ack is finishing its own handshake, not asking anew
      elig0 = req0 & ~ack0_q;
      elig1 = req1 & ~ack1_q;
`ifdef ENCRYPT_ARB_FIXED_PRIO_EN
      pick1 = elig1 & ~elig0;
`else
      // On a tie, serve the requester that was not served last
      pick1 = elig1 & (~elig0 | ~last_q);
`endif
      req_g = g_q ? req1 : req0;

      case (state_q)
         IDLE: begin
            // core_ack may still be high after a mid-transaction reset
            if (!core_ack && (elig0 || elig1)) begin
               g_d        = pick1;
               core_k_d   = pick1 ? k1 : k0;
               core_m_d   = pick1 ? m1 : m0;
               core_req_d = 1'b1;
               state_d    = ISSUE;
            end
         end
         ISSUE: begin
            if (core_ack) begin
               if (g_q) c1_d = core_c;
               else     c0_d = core_c;
               core_req_d = 1'b0;
               state_d    = RELEASE;
            end
         end
         RELEASE: begin
            if (!core_ack) begin
               if (g_q) ack1_d = 1'b1;
               else     ack0_d = 1'b1;
               state_d = RESPOND;
            end
         end
         RESPOND: begin
            if (!req_g) begin
               if (g_q) ack1_d = 1'b0;
               else     ack0_d = 1'b0;
               last_d  = g_q;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign ack0     = ack0_q;
   assign ack1     = ack1_q;
   assign c0       = c0_q;
   assign c1       = c1_q;
   assign core_req = core_req_q;
   assign core_k   = core_k_q;
   assign core_m   = core_m_q;

endmodule

// File: tb/tb_encrypt_arbiter.sv
// Scoreboard bench for encrypt_arbiter. A behavioural core (c = m ^ k) sits on the
// core side; expected responses are queued when stimulus is issued and popped by a
// monitor on every rising ack.

module tb_encrypt_arbiter;

   localparam int unsigned W       = 32;
   localparam int unsigned CORE_LAT = 2;
   localparam int unsigned CORE_DROP = 3;
   localparam int unsigned TMO      = 200;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         req0 = 1'b0, req1 = 1'b0;
   logic         ack0, ack1;
   logic [W-1:0] k0 = '0, m0 = '0, k1 = '0, m1 = '0;
   logic [W-1:0] c0, c1;
   logic         core_req;
   logic         core_ack = 1'b0;
   logic [W-1:0] core_k, core_m;
   logic [W-1:0] core_c = '0;

   int total = 0;
   int bad   = 0;

   typedef struct {
      int           port;
      logic [W-1:0] c;
   } exp_t;
   exp_t exp_q[$];

   logic [W-1:0] vk[8];
   logic [W-1:0] vm[8];
   logic [W-1:0] vc[8];

   encrypt_arbiter #(.N_K(W), .N_B(W)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req0     (req0),
      .ack0     (ack0),
      .k0       (k0),
      .m0       (m0),
      .c0       (c0),
      .req1     (req1),
      .ack1     (ack1),
      .k1       (k1),
      .m1       (m1),
      .c1       (c1),
      .core_req (core_req),
      .core_ack (core_ack),
      .core_k   (core_k),
      .core_m   (core_m),
      .core_c   (core_c)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic timeout(input string name);
      total++;
      bad++;
      $display("FAIL %s: timed out (t=%0t)", name, $time);
   endtask

   task automatic push(input int p, input int v);
      exp_t e;
      e.port = p;
      e.c    = vc[v];
      exp_q.push_back(e);
   endtask

   // Behavioural encrypt core: acks CORE_LAT cycles after req, holds ack CORE_DROP cycles after req falls
   initial begin
      int cnt;
      int dcnt;
      cnt  = 0;
      dcnt = 0;
      forever begin
         @(posedge clk);
         #1;
         if (core_req && !core_ack) begin
            dcnt = 0;
            if (cnt >= int'(CORE_LAT)) begin
               core_c   = core_m ^ core_k;
               core_ack = 1'b1;
               cnt      = 0;
            end else cnt++;
         end else if (!core_req && core_ack) begin
            cnt = 0;
            if (dcnt >= int'(CORE_DROP)) begin
               core_ack = 1'b0;
               dcnt     = 0;
            end else dcnt++;
         end else begin
            cnt  = 0;
            dcnt = 0;
         end
      end
   end

   // Monitor: every rising ack must match the next queued response
   logic pa0 = 1'b0, pa1 = 1'b0;
   task automatic pop_check(input int p, input logic [W-1:0] c);
      exp_t e;
      if (exp_q.size() == 0) begin
         total++;
         bad++;
         $display("FAIL unexpected_ack: port %0d c=%h with empty queue", p, c);
      end else begin
         e = exp_q.pop_front();
         check("grant_port", 64'(p), 64'(e.port));
         check("result_c", 64'(c), 64'(e.c));
      end
   endtask

   always @(negedge clk) begin
      if (ack0 && !pa0) pop_check(0, c0);
      if (ack1 && !pa1) pop_check(1, c1);
      pa0 = ack0;
      pa1 = ack1;
   end

   // Wait (at negedges) until the given port's ack equals val
   task automatic wait_ack(input int p, input logic val, input string name);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (((p == 0) ? ack0 : ack1) !== val && n < int'(TMO));
      if (((p == 0) ? ack0 : ack1) !== val) timeout(name);
   endtask

   // Full 4-phase requester transaction; must be called at a negedge
   task automatic request(input int p, input int v);
      if (p == 0) begin
         k0 = vk[v]; m0 = vm[v]; req0 = 1'b1;
      end else begin
         k1 = vk[v]; m1 = vm[v]; req1 = 1'b1;
      end
      wait_ack(p, 1'b1, "ack_rise");
      if (p == 0) req0 = 1'b0;
      else        req1 = 1'b0;
      wait_ack(p, 1'b0, "ack_fall");
   endtask

   initial begin
      int n;
      bit seen;
      vk[0] = 32'h0000_FFFF; vm[0] = 32'h1234_5678; vc[0] = 32'h1234_A987;
      vk[1] = 32'hFFFF_0000; vm[1] = 32'h1234_5678; vc[1] = 32'hEDCB_5678;
      vk[2] = 32'hAAAA_AAAA; vm[2] = 32'h5555_5555; vc[2] = 32'hFFFF_FFFF;
      vk[3] = 32'h0F0F_0F0F; vm[3] = 32'h0000_0000; vc[3] = 32'h0F0F_0F0F;
      vk[4] = 32'hDEAD_BEEF; vm[4] = 32'hDEAD_BEEF; vc[4] = 32'h0000_0000;
      vk[5] = 32'h1111_1111; vm[5] = 32'h2222_2222; vc[5] = 32'h3333_3333;
      vk[6] = 32'h8000_0001; vm[6] = 32'h0000_0001; vc[6] = 32'h8000_0000;
      vk[7] = 32'h0000_00FF; vm[7] = 32'hCAFE_0000; vc[7] = 32'hCAFE_00FF;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_ack0", 64'(ack0), 64'd0);
      check("rst_ack1", 64'(ack1), 64'd0);
      check("rst_core_req", 64'(core_req), 64'd0);
      check("rst_core_k", 64'(core_k), 64'd0);
      check("rst_core_m", 64'(core_m), 64'd0);
      check("rst_c0", 64'(c0), 64'd0);
      check("rst_c1", 64'(c1), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Single requester: one-cycle grant latency, port 1 untouched
      push(0, 0);
      fork
         request(0, 0);
         begin
            check("pre_grant_core_req", 64'(core_req), 64'd0);
            @(negedge clk);
            check("grant_latency", 64'(core_req), 64'd1);
            check("grant_core_k", 64'(core_k), 64'(vk[0]));
            check("grant_core_m", 64'(core_m), 64'(vm[0]));
         end
      join
      check("single_ack1", 64'(ack1), 64'd0);
      check("single_c1", 64'(c1), 64'd0);
      check("single_c0_held", 64'(c0), 64'(vc[0]));

      // Reset while the core is busy in ISSUE; result is discarded
      req0 = 1'b1; k0 = vk[2]; m0 = vm[2];
      n = 0;
      while (core_ack !== 1'b1 && n < int'(TMO)) begin
         @(negedge clk);
         n++;
      end
      if (core_ack !== 1'b1) timeout("core_busy");
      rst_n = 1'b0;
      req0  = 1'b0;
      #1;
      check("midrst_ack0", 64'(ack0), 64'd0);
      check("midrst_ack1", 64'(ack1), 64'd0);
      check("midrst_core_req", 64'(core_req), 64'd0);
      check("midrst_c0", 64'(c0), 64'd0);
      #2;
      rst_n = 1'b1;
      @(negedge clk);
      check("core_ack_still_high", 64'(core_ack), 64'd1);
      push(0, 3);
      fork
         request(0, 3);
         begin
            for (int i = 0; i < int'(TMO); i++) begin
               if (core_ack !== 1'b1) break;
               check("no_issue_while_core_ack", 64'(core_req), 64'd0);
               @(negedge clk);
            end
         end
      join

      // Port 1 raised mid-transaction of port 0: held off until ack0 falls
      push(0, 1);
      push(1, 5);
      fork
         request(0, 1);
         begin
            n = 0;
            while (core_req !== 1'b1 && n < int'(TMO)) begin
               @(negedge clk);
               n++;
            end
            if (core_req !== 1'b1) timeout("mid_core_req");
            request(1, 5);
         end
         begin
            n = 0;
            while (core_req !== 1'b1 && n < int'(TMO)) begin
               @(negedge clk);
               n++;
            end
            while (core_req === 1'b1 && n < int'(TMO)) begin
               @(negedge clk);
               n++;
            end
            seen = 1'b0;
            for (int i = 0; i < int'(TMO); i++) begin
               if (seen && !ack0) break;
               if (ack0) seen = 1'b1;
               check("pending_hold_off", 64'(core_req), 64'd0);
               @(negedge clk);
            end
            @(negedge clk);
            check("pending_grant_1cyc", 64'(core_req), 64'd1);
            check("pending_grant_k", 64'(core_k), 64'(vk[5]));
         end
      join

      // Simultaneous requests: port 0 first
      push(0, 0);
      push(1, 1);
      fork
         request(0, 0);
         request(1, 1);
      join
      check("tie_c0", 64'(c0), 64'(vc[0]));
      check("tie_c1", 64'(c1), 64'(vc[1]));

      // Continuous contention, 4 rounds per port
`ifdef ENCRYPT_ARB_FIXED_PRIO_EN
      for (int r = 0; r < 4; r++) push(0, r);
      for (int r = 0; r < 4; r++) push(1, 4 + r);
`else
      for (int r = 0; r < 4; r++) begin
         push(0, r);
         push(1, 4 + r);
      end
`endif
      fork
         for (int r = 0; r < 4; r++) request(0, r);
         for (int r = 0; r < 4; r++) request(1, 4 + r);
      join

      repeat (5) @(negedge clk);
      check("queue_drained", 64'(exp_q.size()), 64'd0);
      check("final_idle_core_req", 64'(core_req), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule
